// File: rtl/uart_rx_buf_pkg.sv
// Shared types and constants for the UART receive buffer: FSM encoding, entry layout and
// drop-counter saturation.
package uart_rx_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } state_e;

  localparam int unsigned ENTRY_W = 11;
  localparam int unsigned PERR_B  = 8;
  localparam int unsigned FERR_B  = 9;
  localparam int unsigned OVF_B   = 10;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-side and host-side signals of the UART receive buffer; the buffer uses the slave
// view, the receiver/host environment uses the master view.
interface uart_rx_buffer_if
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned AW = 4
);
  logic               rx_rdy;
  logic [7:0]         rx_data;
  logic               rx_perr;
  logic               rx_ferr;
  logic               rx_ovf;
  logic               read;
  logic               pop;
  logic [7:0]         dout;
  logic [ENTRY_W-9:0] dout_err;
  logic               empty;
  logic               full;
  logic [AW:0]        count;
  logic [7:0]         drop_cnt;

  modport slave (
    input  rx_rdy, rx_data, rx_perr, rx_ferr, rx_ovf, pop,
    output read, dout, dout_err, empty, full, count, drop_cnt
  );

  modport master (
    output rx_rdy, rx_data, rx_perr, rx_ferr, rx_ovf, pop,
    input  read, dout, dout_err, empty, full, count, drop_cnt
  );
endinterface

// File: rtl/uart_rx_buf_mem.sv
// FIFO storage: DEPTH x ENTRY_W register array, synchronous write, asynchronous (show-ahead)
// read. Storage is deliberately not reset.
module uart_rx_buf_mem
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);
  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_buffer.sv
// Captures bytes from the UART receiver holding register into a FWFT FIFO and acks each one.
// Define UART_RX_BUF_DROP_ERR_EN to discard bytes that carry parity or framing errors.
module uart_rx_buffer
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_rx_buffer_if.slave   bus
);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  state_e             state;
  logic [ENTRY_W-1:0] cap_q;
  logic               read_q;
  logic [7:0]         drop_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic [ENTRY_W-1:0] head;
  logic               full, empty, push, pop_ok, err_drop;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);

`ifdef UART_RX_BUF_DROP_ERR_EN
  assign err_drop = cap_q[PERR_B] | cap_q[FERR_B];
`else
  assign err_drop = 1'b0;
`endif

  // A push is judged on the full flag at this edge; a same-cycle pop does not make room.
  assign push   = (state == WRITE) && !full && !err_drop;
  assign pop_ok = bus.pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cap_q  <= '0;
      read_q <= 1'b0;
      drop_q <= '0;
    end else begin
      read_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.rx_rdy) begin
            cap_q <= {bus.rx_ovf, bus.rx_ferr, bus.rx_perr, bus.rx_data};
            state <= WRITE;
          end
        end
        WRITE: begin
          if (full || err_drop) drop_q <= sat_inc(drop_q);
          read_q <= 1'b1;
          state  <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  uart_rx_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (cap_q),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign bus.read     = read_q;
  assign bus.dout     = head[7:0];
  assign bus.dout_err = head[OVF_B:PERR_B];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomized bench for uart_rx_buffer: a sticky-flag receiver model drives the buffer and a
// queue-based reference predicts every output each cycle.
module tb_uart_rx_buffer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef UART_RX_BUF_DROP_ERR_EN
  localparam bit DropErr = 1'b1;
`else
  localparam bit DropErr = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_buffer_if #(.AW(AW)) bus ();

  uart_rx_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: byte seen on rx_rdy at an idle edge is pushed one edge later (unless full or
  // error-dropped) and acked during the cycle after that; the next capture needs 3 edges.
  logic [10:0] mq[$];
  int          m_drop      = 0;
  int          m_edge      = 0;
  int          m_idle_from = 0;
  int          m_push_edge = -1;
  int          m_read_edge = -1;
  logic [10:0] m_pend      = '0;
  bit          m_do_push, m_was_full, m_do_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_drop      = 0;
      m_push_edge = -1;
      m_read_edge = -1;
      m_idle_from = m_edge + 1;
    end else begin
      m_edge++;
      m_was_full = (mq.size() == DEPTH);
      m_do_pop   = bus.pop && (mq.size() != 0);
      m_do_push  = 1'b0;
      if (m_push_edge == m_edge) begin
        if (m_was_full || (DropErr && (m_pend[8] || m_pend[9]))) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_do_push = 1'b1;
        end
      end
      if (m_do_pop)  void'(mq.pop_front());
      if (m_do_push) mq.push_back(m_pend);
      if (m_edge >= m_idle_from && bus.rx_rdy) begin
        m_pend      = {bus.rx_ovf, bus.rx_ferr, bus.rx_perr, bus.rx_data};
        m_push_edge = m_edge + 1;
        m_read_edge = m_edge + 1;
        m_idle_from = m_edge + 3;
      end
    end
  end

  // Stimulus state
  logic [10:0] txq[$];
  bit          b2b      = 1'b0;
  int          pop_mode = 0;
  int          cyc      = 0;
  int          n_reads  = 0;
  int          max_cnt  = 0;

  task automatic load();
    logic [10:0] e;
    e = txq.pop_front();
    bus.rx_data = e[7:0];
    bus.rx_perr = e[8];
    bus.rx_ferr = e[9];
    bus.rx_ovf  = e[10];
    bus.rx_rdy  = 1'b1;
  endtask

  // Receiver clears its sticky flag on the ack; a new byte may land in the same cycle.
  task automatic drive();
    if (!reset) begin
      if (bus.read) begin
        bus.rx_rdy = 1'b0;
        if (b2b && txq.size() != 0) load();
      end else if (!bus.rx_rdy && txq.size() != 0 && (b2b || $urandom_range(0, 2) == 0)) begin
        load();
      end
    end
    case (pop_mode)
      0:       bus.pop = 1'b0;
      1:       bus.pop = ($urandom_range(0, 2) == 0);
      2:       bus.pop = (cyc % 3 == 0);
      default: bus.pop = 1'b1;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_eq("read", 32'(bus.read), 32'(m_read_edge == m_edge));
    if (bus.read) n_reads++;
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    check_eq("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check_eq("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    check_eq("count", 32'(bus.count), 32'(mq.size()));
    check_eq("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    if (mq.size() != 0) begin
      check_eq("dout", 32'(bus.dout), 32'(mq[0][7:0]));
      check_eq("dout_err", 32'(bus.dout_err), 32'(mq[0][10:8]));
    end
    drive();
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    int k = 0;
    while (k < max_cyc && !(txq.size() == 0 && !bus.rx_rdy && m_edge > m_push_edge)) begin
      step();
      k++;
    end
    check_eq(tag, 32'(k < max_cyc), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    pop_mode = 3;
    while (k < 100 && mq.size() != 0) begin
      step();
      k++;
    end
    check_eq(tag, 32'(mq.size()), 32'd0);
    pop_mode = 0;
    bus.pop  = 1'b0;
  endtask

  function automatic logic [10:0] rand_entry(input bit with_flags);
    logic [10:0] e;
    e = 11'($urandom);
    if (!with_flags) e[10:8] = 3'b000;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    int k;
    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.rx_perr = 1'b0;
    bus.rx_ferr = 1'b0; bus.rx_ovf = 1'b0; bus.pop = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single byte
    n_reads = 0;
    txq.push_back({3'b000, 8'hA5});
    run_until_idle(50, "single_idle");
    check_eq("single_dout", 32'(bus.dout), 32'h0A5);
    check_eq("single_err", 32'(bus.dout_err), 32'd0);
    check_eq("single_count", 32'(bus.count), 32'd1);
    check_eq("single_reads", 32'(n_reads), 32'd1);
    drain("single_drain");
    step();

    // Status capture: ovf=1, ferr=1
    n_reads = 0;
    txq.push_back({3'b110, 8'h3C});
    run_until_idle(50, "status_idle");
    check_eq("status_count", 32'(bus.count), DropErr ? 32'd0 : 32'd1);
    check_eq("status_drop", 32'(bus.drop_cnt), DropErr ? 32'd1 : 32'd0);
    check_eq("status_reads", 32'(n_reads), 32'd1);
    if (bus.count != 0) check_eq("status_err", 32'(bus.dout_err), 32'b110);
    drain("status_drain");

    // Fill and overflow
    d0 = m_drop;
    for (int i = 0; i <= 16; i++) txq.push_back({3'b000, 8'(i)});
    run_until_idle(300, "fill_idle");
    check_eq("fill_full", 32'(bus.full), 32'd1);
    check_eq("fill_count", 32'(bus.count), 32'd16);
    check_eq("fill_drop", 32'(bus.drop_cnt), 32'(d0 + 1));
    pop_mode = 3;
    bus.pop  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("fill_order", 32'(bus.dout), 32'(i));
      step();
    end
    pop_mode = 0;
    bus.pop  = 1'b0;
    check_eq("fill_empty", 32'(bus.empty), 32'd1);

    // Wrap with concurrent traffic, pop every third cycle
    max_cnt  = 0;
    pop_mode = 2;
    for (int i = 0; i < 40; i++) txq.push_back(rand_entry(1'b1));
    run_until_idle(600, "wrap_idle");
    drain("wrap_drain");
    pop_mode = 3;
    repeat (3) step();
    pop_mode = 0;
    bus.pop  = 1'b0;
    check_eq("wrap_max_count", 32'(max_cnt <= DEPTH), 32'd1);
    check_eq("pop_empty_count", 32'(bus.count), 32'd0);

    // Back-to-back: second byte lands with the ack
    n_reads = 0;
    b2b = 1'b1;
    txq.push_back({3'b000, 8'h11});
    txq.push_back({3'b000, 8'h5A});
    run_until_idle(50, "b2b_idle");
    check_eq("b2b_reads", 32'(n_reads), 32'd2);
    check_eq("b2b_count", 32'(bus.count), 32'd2);
    drain("b2b_drain");

    // Random traffic, both pacing styles
    for (int r = 0; r < 2; r++) begin
      b2b      = (r == 1);
      pop_mode = 1;
      for (int i = 0; i < 60; i++) txq.push_back(rand_entry(1'b1));
      run_until_idle(1000, "rand_idle");
      drain("rand_drain");
    end

    // Drop counter saturation
    b2b = 1'b1;
    for (int i = 0; i < 300; i++) txq.push_back(rand_entry(1'b0));
    run_until_idle(2000, "sat_idle");
    check_eq("sat_drop", 32'(bus.drop_cnt), 32'd255);
    b2b = 1'b0;
    drain("sat_drain");

    // Reset while in WRITE; pending byte re-captured exactly once afterwards
    txq.push_back({3'b000, 8'h77});
    k = 0;
    while (k < 50 && m_push_edge != m_edge + 1) begin
      step();
      k++;
    end
    check_eq("rst_reach_write", 32'(k < 50), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_read", 32'(bus.read), 32'd0);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_drop", 32'(bus.drop_cnt), 32'd0);
    repeat (2) step();
    n_reads = 0;
    reset   = 1'b0;
    run_until_idle(50, "rst_idle");
    check_eq("rst_recap_count", 32'(bus.count), 32'd1);
    check_eq("rst_recap_dout", 32'(bus.dout), 32'h077);
    check_eq("rst_recap_reads", 32'(n_reads), 32'd1);
    drain("rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
